// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared VGA constants and types for the camera frame-buffer capture and
// display blocks.
//  - 640x480@60 horizontal/vertical timing (visible, porches, sync, totals)
//  - RGB444 word width and frame-buffer address width
//  - vga_ctl_t: per-pixel control bundle carried down the display pipeline
//  - bar_rgb(): colour of the 8-bar test pattern for a given column
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;  // 800

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;  // 525

  localparam int RGB_W = 12;  // {R[3:0],G[3:0],B[3:0]}
  localparam int FB_AW = 19;  // addr = y*640+x, max 307199
  localparam int CNT_W = 10;  // wide enough for both hcnt and vcnt

  typedef logic [RGB_W-1:0] rgb_t;

  typedef struct packed {
    logic active;  // pixel is inside the visible window
    logic hs_n;    // horizontal sync, active low
    logic vs_n;    // vertical sync, active low
    logic first;   // first visible pixel of the frame
  } vga_ctl_t;

  // Value of the control bundle while nothing is being displayed.
  localparam vga_ctl_t CTL_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1, first: 1'b0};

  typedef enum logic [2:0] {
    BAR_WHITE, BAR_YELLOW, BAR_CYAN, BAR_GREEN,
    BAR_MAGENTA, BAR_RED, BAR_BLUE, BAR_BLACK
  } bar_e;

  // Eight vertical bars of 80 pixels each across the visible width.
  function automatic rgb_t bar_rgb(input logic [CNT_W-1:0] x);
    logic [2:0] idx;
    rgb_t       c;
    idx = 3'(x / CNT_W'(80));
    c   = '0;
    case (bar_e'(idx))
      BAR_WHITE:   c = 12'hFFF;
      BAR_YELLOW:  c = 12'hFF0;
      BAR_CYAN:    c = 12'h0FF;
      BAR_GREEN:   c = 12'h0F0;
      BAR_MAGENTA: c = 12'hF0F;
      BAR_RED:     c = 12'hF00;
      BAR_BLUE:    c = 12'h00F;
      default:     c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Horizontal/vertical raster counters and the stage-0 control bundle.
// Porch and sync widths are fixed; only the visible width/height scale with
// the parameters.
// Ports:
//  pclk  in   pixel clock, all logic on posedge
//  rst   in   asynchronous active-high reset, counters restart at (0,0)
//  hcnt  out  current column 0..H_VIS+159
//  vcnt  out  current line   0..V_VIS+44
//  ctl   out  stage-0 active / hs_n / vs_n / first-pixel for (hcnt,vcnt)
// ---------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS = vga_pkg::H_VIS,
  parameter int V_VIS = vga_pkg::V_VIS
) (
  input  logic             pclk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output vga_ctl_t         ctl
);

  // Blanking intervals are taken from the package; the visible part follows
  // the parameters.
  localparam int HT = H_TOTAL - vga_pkg::H_VIS + H_VIS;
  localparam int VT = V_TOTAL - vga_pkg::V_VIS + V_VIS;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] H_VIS_C   = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C   = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_comb begin
    ctl.active = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
    ctl.hs_n   = !((hcnt >= H_SYNC_LO) && (hcnt <= H_SYNC_HI));
    ctl.vs_n   = !((vcnt >= V_SYNC_LO) && (vcnt <= V_SYNC_HI));
    ctl.first  = (hcnt == '0) && (vcnt == '0);
  end

endmodule

// File: rtl/vga_framebuffer_reader.sv
// ---------------------------------------------------------------------------
// vga_framebuffer_reader
// Read side of the camera frame buffer: 640x480@60 VGA timing on the 25 MHz
// pixel clock, one frame-buffer read per visible pixel, RGB444 + active-low
// syncs to the DAC pins. Counter state reaches the pins RD_LAT+1 cycles later.
// Build option: define VGA_TEST_PATTERN_EN to add the 8-bar colour test
// pattern selected by pattern_sel; otherwise pattern_sel is ignored.
// Parameters:
//  RD_LAT  frame-buffer read latency in pclk cycles (1..3)
//  H_VIS   visible pixels per line
//  V_VIS   visible lines per frame
// Ports:
//  pclk         in   pixel clock, all logic on posedge
//  rst          in   asynchronous active-high reset
//  rd_addr      out  frame-buffer read address, y*H_VIS+x while visible
//  rd_data      in   {R,G,B} word, valid RD_LAT cycles after rd_addr
//  pattern_sel  in   test pattern select (VGA_TEST_PATTERN_EN builds only)
//  vga_r/g/b    out  4-bit colour, black during blanking
//  vga_hs/vs    out  syncs, active low
//  frame_start  out  one-cycle pulse on the first visible pixel of a frame
// ---------------------------------------------------------------------------
module vga_framebuffer_reader
  import vga_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int H_VIS  = vga_pkg::H_VIS,
  parameter int V_VIS  = vga_pkg::V_VIS
) (
  input  logic             pclk,
  input  logic             rst,
  output logic [FB_AW-1:0] rd_addr,
  input  logic [RGB_W-1:0] rd_data,
  input  logic             pattern_sel,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             frame_start
);

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  vga_ctl_t         ctl0;
  vga_ctl_t         ctl_pipe [RD_LAT];
  vga_ctl_t         ctl_d;
  logic             last_px;
  rgb_t             pix;

  vga_timing #(
    .H_VIS (H_VIS),
    .V_VIS (V_VIS)
  ) u_timing (
    .pclk (pclk),
    .rst  (rst),
    .hcnt (hcnt),
    .vcnt (vcnt),
    .ctl  (ctl0)
  );

  // Running address instead of y*H_VIS+x: step on every visible pixel, hold
  // through blanking, and restart right after the last visible pixel so the
  // address never leaves 0..H_VIS*V_VIS-1.
  assign last_px = (hcnt == CNT_W'(H_VIS - 1)) && (vcnt == CNT_W'(V_VIS - 1));

  always_ff @(posedge pclk or posedge rst) begin
    if (rst)              rd_addr <= '0;
    else if (last_px)     rd_addr <= '0;
    else if (ctl0.active) rd_addr <= rd_addr + 1'b1;
  end

  // Control bundle delayed by the read latency so it lines up with rd_data.
  // NOTE: the delay line is only RD_LAT small flops, so it is reset like any
  // other register; that guarantees blank/idle syncs straight out of reset.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) ctl_pipe[i] <= CTL_IDLE;
    end else begin
      ctl_pipe[0] <= ctl0;
      for (int i = 1; i < RD_LAT; i++) ctl_pipe[i] <= ctl_pipe[i-1];
    end
  end

  assign ctl_d = ctl_pipe[RD_LAT-1];

`ifdef VGA_TEST_PATTERN_EN
  // Pattern colour is computed at stage 0 and travels with the control bits,
  // giving it exactly the latency of frame data.
  rgb_t pat_pipe [RD_LAT];
  logic pat_sel_pipe [RD_LAT];

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pat_pipe[i]     <= '0;
        pat_sel_pipe[i] <= 1'b0;
      end
    end else begin
      pat_pipe[0]     <= bar_rgb(hcnt);
      pat_sel_pipe[0] <= pattern_sel;
      for (int i = 1; i < RD_LAT; i++) begin
        pat_pipe[i]     <= pat_pipe[i-1];
        pat_sel_pipe[i] <= pat_sel_pipe[i-1];
      end
    end
  end
`else
  // Port kept for the fixed pinout; nothing is built behind it.
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
`endif

  // NOTE: pix gets its default before any condition, so every path assigns
  // it and no latch is inferred.
  always_comb begin
    pix = '0;
    if (ctl_d.active) begin
`ifdef VGA_TEST_PATTERN_EN
      pix = pat_sel_pipe[RD_LAT-1] ? pat_pipe[RD_LAT-1] : rd_data;
`else
      pix = rd_data;
`endif
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      {vga_r, vga_g, vga_b} <= '0;
      vga_hs                <= 1'b1;
      vga_vs                <= 1'b1;
      frame_start           <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= pix;
      vga_hs                <= ctl_d.hs_n;
      vga_vs                <= ctl_d.vs_n;
      frame_start           <= ctl_d.first;
    end
  end

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// ---------------------------------------------------------------------------
// tb_vga_framebuffer_reader
// Four readers share clock and reset: dut0 is full 640x480 with RD_LAT=1,
// dut1..dut3 are 32x4 rasters (same porches/syncs) with RD_LAT=1,2,3 so whole
// frames fit in a short run. Expected pins come from the raster position
// (cycle index -> x,y) and the display rules; a RAM model answers reads.
// ---------------------------------------------------------------------------
module tb_vga_framebuffer_reader;

  localparam int N_DUT = 4;
`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  logic                   pclk = 1'b0;
  logic                   rst;
  logic [N_DUT-1:0][18:0] rd_addr;
  logic [N_DUT-1:0][11:0] rd_data;
  logic [N_DUT-1:0]       psel;
  logic [N_DUT-1:0][3:0]  vga_r, vga_g, vga_b;
  logic [N_DUT-1:0]       vga_hs, vga_vs, frame_start;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  logic [11:0] lut [4096];
  bit          psel_line [525];
  int          addr_hist [N_DUT][8];
  bit          prev_hs [N_DUT], prev_vs [N_DUT];
  int          hs_fall [N_DUT], vs_fall [N_DUT], fs_last [N_DUT], fs_cnt [N_DUT];

  always #20 pclk = ~pclk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    vga_framebuffer_reader #(
      .RD_LAT ((g == 0) ? 1 : g),
      .H_VIS  ((g == 0) ? 640 : 32),
      .V_VIS  ((g == 0) ? 480 : 4)
    ) u_dut (
      .pclk        (pclk),
      .rst         (rst),
      .rd_addr     (rd_addr[g]),
      .rd_data     (rd_data[g]),
      .pattern_sel (psel[g]),
      .vga_r       (vga_r[g]),
      .vga_g       (vga_g[g]),
      .vga_b       (vga_b[g]),
      .vga_hs      (vga_hs[g]),
      .vga_vs      (vga_vs[g]),
      .frame_start (frame_start[g])
    );
  end

  function automatic int lat_of(int d); return (d == 0) ? 1 : d;    endfunction
  function automatic int hv_of(int d);  return (d == 0) ? 640 : 32; endfunction
  function automatic int vv_of(int d);  return (d == 0) ? 480 : 4;  endfunction

  // Frame contents: dut0 returns addr[11:0], the small rasters a random table.
  function automatic logic [11:0] ram_word(int d, int addr);
    if (d == 0) return 12'(addr);
    return lut[addr & 4095];
  endfunction

  function automatic logic [11:0] bar_colour(int x);
    case (x / 80)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s dut%0d n=%0d: observed=%0h expected=%0h", tag, d, n, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < N_DUT; d++) begin
      check({tag, "_addr"}, d, rd_addr[d], 0);
      check({tag, "_rgb"},  d, {vga_r[d], vga_g[d], vga_b[d]}, 12'h000);
      check({tag, "_hs"},   d, vga_hs[d], 1);
      check({tag, "_vs"},   d, vga_vs[d], 1);
      check({tag, "_fs"},   d, frame_start[d], 0);
    end
  endtask

  // Compare every DUT against the raster model for cycle n, answer its read,
  // and measure sync pulses.
  task automatic sample();
    for (int d = 0; d < N_DUT; d++) begin
      int L, hv, vv, ht, ft, p, x, y, m, mx, my;
      logic [11:0] ergb;
      logic ehs, evs, efs;
      L  = lat_of(d); hv = hv_of(d); vv = vv_of(d);
      ht = hv + 160;  ft = ht * (vv + 45);
      p = n % ft; x = p % ht; y = p / ht;
      if (x < hv && y < vv) check("rd_addr", d, rd_addr[d], y * hv + x);
      else                  check("rd_addr_range", d, rd_addr[d] < hv * vv, 1);

      addr_hist[d][n % 8] = rd_addr[d];
      rd_data[d] = (n >= L) ? ram_word(d, addr_hist[d][(n - L) % 8]) : 12'h000;

      if (n < L + 1) begin
        ergb = 12'h000; ehs = 1'b1; evs = 1'b1; efs = 1'b0;
      end else begin
        m = n - L - 1; p = m % ft; mx = p % ht; my = p / ht;
        ehs = !(mx >= hv + 16 && mx < hv + 112);
        evs = !(my >= vv + 10 && my < vv + 12);
        efs = (p == 0);
        if (!(mx < hv && my < vv))             ergb = 12'h000;
        else if (d == 0 && PAT_EN && psel_line[my]) ergb = bar_colour(mx);
        else                                   ergb = ram_word(d, my * hv + mx);
      end
      check("rgb", d, {vga_r[d], vga_g[d], vga_b[d]}, ergb);
      check("hs",  d, vga_hs[d], ehs);
      check("vs",  d, vga_vs[d], evs);
      check("fs",  d, frame_start[d], efs);

      if (prev_hs[d] && !vga_hs[d]) begin
        check("hs_fall_pos", d, (n >= L + 1) ? (n - L - 1) % ht : -1, hv + 16);
        if (hs_fall[d] >= 0) check("line_period", d, n - hs_fall[d], ht);
        hs_fall[d] = n;
      end
      if (!prev_hs[d] && vga_hs[d]) check("hs_low_width", d, n - hs_fall[d], 96);
      if (prev_vs[d] && !vga_vs[d]) begin
        check("vs_fall_pos", d, (n >= L + 1) ? (n - L - 1) % ft : -1, (vv + 10) * ht);
        if (vs_fall[d] >= 0) check("frame_period_vs", d, n - vs_fall[d], ft);
        vs_fall[d] = n;
      end
      if (!prev_vs[d] && vga_vs[d]) check("vs_low_width", d, n - vs_fall[d], 2 * ht);
      if (frame_start[d]) begin
        fs_cnt[d]++;
        if (fs_last[d] >= 0) check("frame_period_fs", d, n - fs_last[d], ft);
        fs_last[d] = n;
      end
      prev_hs[d] = vga_hs[d];
      prev_vs[d] = vga_vs[d];
    end
    // pattern_sel for dut0 changes only deep in horizontal blanking.
    begin
      int x0, y0;
      x0 = (n % 420000) % 800; y0 = (n % 420000) / 800;
      psel[0] = (x0 >= 740) ? psel_line[(y0 + 1) % 525] : psel_line[y0];
    end
  endtask

  // Spot checks with hand-derived values.
  task automatic directed();
    if (n == 800 + 5 + 2) check("px_5_1", 0, {vga_r[0], vga_g[0], vga_b[0]}, 12'h285);
    if (n == 650 + 2)     check("blank_black", 0, {vga_r[0], vga_g[0], vga_b[0]}, 12'h000);
    if (n == 1600 + 2)    check("pat_x0",   0, {vga_r[0], vga_g[0], vga_b[0]}, PAT_EN ? 12'hFFF : 12'h500);
    if (n == 1600 + 87)   check("pat_x85",  0, {vga_r[0], vga_g[0], vga_b[0]}, PAT_EN ? 12'hFF0 : 12'h555);
    if (n == 1600 + 641)  check("pat_x639", 0, {vga_r[0], vga_g[0], vga_b[0]}, PAT_EN ? 12'h000 : 12'h77F);
    if (n == 639)         check("addr_line0_end", 0, rd_addr[0], 639);
    if (n == 800)         check("addr_line1_start", 0, rd_addr[0], 640);
    for (int d = 1; d < N_DUT; d++) begin
      if (n == 3 * 192 + 31) check("addr_last", d, rd_addr[d], 127);
      if (n == 9408)         check("addr_wrap", d, rd_addr[d], 0);
    end
  endtask

  task automatic release_rst();
    @(negedge pclk);
    rst = 1'b0;
    for (int d = 0; d < N_DUT; d++) begin
      prev_hs[d] = 1'b1; prev_vs[d] = 1'b1;
      hs_fall[d] = -1; vs_fall[d] = -1; fs_last[d] = -1; fs_cnt[d] = 0;
    end
    n = 0;
    #1;
    sample();
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(posedge pclk);
      #1;
      n++;
      sample();
      directed();
    end
  endtask

  initial begin
    rst     = 1'b1;
    rd_data = '0;
    psel    = '0;
    for (int i = 0; i < 4096; i++) lut[i] = 12'($urandom);
    for (int i = 0; i < 525; i++)  psel_line[i] = 1'($urandom);
    psel_line[0] = 1'b0;
    psel_line[1] = 1'b0;
    psel_line[2] = 1'b1;

    repeat (3) @(posedge pclk);
    #1;
    check_reset("rst_initial");

    // Short run, then reset asynchronously in the middle of a line.
    release_rst();
    run(100 + $urandom_range(0, 500));
    #7;
    rst = 1'b1;
    for (int d = 0; d < N_DUT; d++) rd_data[d] = 12'($urandom) | 12'h001;
    #1;
    check_reset("rst_async");
    repeat (3) begin
      @(posedge pclk);
      #1;
      check_reset("rst_hold");
    end

    // Two full small frames plus the first lines of the full-size raster.
    release_rst();
    run(2 * 9408 + 600);

    for (int d = 0; d < N_DUT; d++) begin
      int ft;
      ft = (hv_of(d) + 160) * (vv_of(d) + 45);
      check("frame_start_count", d, fs_cnt[d], (n - lat_of(d) - 1) / ft + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
